// File: rtl/call_register.sv
// Elevator call register: edge-detected car/hall buttons latched into pending
// call sets, cleared on serve, with registered next-target selection.
module call_register #(
  parameter int FLOORS     = 6,
  parameter int FLOOR_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOORS-1:0]     btn_num_in,
  input  logic [FLOORS-1:0]     btn_up_out,
  input  logic [FLOORS-1:0]     btn_down_out,
  input  logic                  service,
  input  logic [FLOOR_BITS-1:0] current_floor,
  input  logic                  dir_up,
  input  logic                  serve,
  output logic [FLOORS-1:0]     pending_car,
  output logic [FLOORS-1:0]     pending_up,
  output logic [FLOORS-1:0]     pending_down,
  output logic [FLOOR_BITS-1:0] target_floor,
  output logic                  target_valid,
  output logic                  req_here
);

  // No up call exists at the top floor and no down call at the ground floor.
  localparam logic [FLOORS-1:0]   UP_MASK    = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0]   DOWN_MASK  = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FLOORS-1:0]   GROUND_BIT = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FLOORS-1:0]   TOP_BIT    = {1'b1, {(FLOORS-1){1'b0}}};
  localparam logic [FLOOR_BITS:0] FLOORS_W   = FLOORS[FLOOR_BITS:0];

  logic [FLOORS-1:0] car_q, car_qq, up_q, up_qq, down_q, down_qq;

  logic                  in_range;
  logic [FLOORS-1:0]     cur_onehot;
  logic [FLOORS-1:0]     clr_car, clr_up, clr_down;
  logic [FLOORS-1:0]     nxt_car, nxt_up, nxt_down, all_calls;
  logic                  found_above, found_below;
  logic [FLOOR_BITS-1:0] above_idx, below_idx;
  logic                  nxt_here, nxt_valid;
  logic [FLOOR_BITS-1:0] nxt_target;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
    in_range    = ({1'b0, current_floor} < FLOORS_W);
    cur_onehot  = '0;
    found_above = 1'b0;
    found_below = 1'b0;
    above_idx   = '0;
    below_idx   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      cur_onehot[i] = in_range && (current_floor == FLOOR_BITS'(i));
    end

    // Floor 0 always clears the up call, the top floor always clears the down call.
    clr_car  = serve ? cur_onehot : '0;
    clr_up   = serve ? (cur_onehot & (dir_up ? '1 : GROUND_BIT)) : '0;
    clr_down = serve ? (cur_onehot & (dir_up ? TOP_BIT : '1)) : '0;

    // Clear is applied after set, so a press coinciding with serve is dropped.
    nxt_car  = service ? '0 : ((pending_car  | (car_q  & ~car_qq))             & ~clr_car);
    nxt_up   = service ? '0 : ((pending_up   | (up_q   & ~up_qq   & UP_MASK))   & ~clr_up);
    nxt_down = service ? '0 : ((pending_down | (down_q & ~down_qq & DOWN_MASK)) & ~clr_down);
    all_calls = nxt_car | nxt_up | nxt_down;

    // Descending scan leaves the lowest hit above; ascending leaves the highest below.
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (all_calls[i] && (FLOOR_BITS'(i) > current_floor)) begin
        found_above = 1'b1;
        above_idx   = FLOOR_BITS'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (all_calls[i] && (FLOOR_BITS'(i) < current_floor)) begin
        found_below = 1'b1;
        below_idx   = FLOOR_BITS'(i);
      end
    end

    nxt_here   = !service && in_range && |(all_calls & cur_onehot);
    nxt_valid  = 1'b0;
    nxt_target = target_floor;
    if (!service && in_range) begin
      if (dir_up && found_above) begin
        nxt_valid  = 1'b1;
        nxt_target = above_idx;
      end else if (!dir_up && found_below) begin
        nxt_valid  = 1'b1;
        nxt_target = below_idx;
      end else if (dir_up && found_below) begin
        nxt_valid  = 1'b1;
        nxt_target = below_idx;
      end else if (!dir_up && found_above) begin
        nxt_valid  = 1'b1;
        nxt_target = above_idx;
      end else if (nxt_here) begin
        nxt_valid  = 1'b1;
        nxt_target = current_floor;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    car_q  <= btn_num_in;
    up_q   <= btn_up_out;
    down_q <= btn_down_out;
    if (reset) begin
      // History takes the live levels so buttons held through reset do not latch.
      car_qq       <= btn_num_in;
      up_qq        <= btn_up_out;
      down_qq      <= btn_down_out;
      pending_car  <= '0;
      pending_up   <= '0;
      pending_down <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      req_here     <= 1'b0;
    end else begin
      car_qq       <= car_q;
      up_qq        <= up_q;
      down_qq      <= down_q;
      pending_car  <= nxt_car;
      pending_up   <= nxt_up;
      pending_down <= nxt_down;
      target_floor <= nxt_target;
      target_valid <= nxt_valid;
      req_here     <= nxt_here;
    end
  end

endmodule

// File: tb/tb_call_register.sv
// Self-checking bench for call_register: directed scenarios plus randomized
// traffic compared against a per-floor behavioural model.
module tb_call_register;

  localparam int F  = 6;
  localparam int FB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [F-1:0]  btn_num_in = '0, btn_up_out = '0, btn_down_out = '0;
  logic          service = 1'b0, dir_up = 1'b1, serve = 1'b0;
  logic [FB-1:0] current_floor = '0;
  logic [F-1:0]  pending_car, pending_up, pending_down;
  logic [FB-1:0] target_floor;
  logic          target_valid, req_here;

  int total = 0;
  int bad   = 0;

  // Model state: buttons as seen one and two sampling edges ago, plus call sets.
  logic [F-1:0]  s1_car, s2_car, s1_up, s2_up, s1_dn, s2_dn;
  logic [F-1:0]  m_car, m_up, m_dn;
  logic [FB-1:0] m_tgt;
  logic          m_valid, m_here;

  call_register #(.FLOORS(F), .FLOOR_BITS(FB)) dut (
    .clk(clk), .reset(reset),
    .btn_num_in(btn_num_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
    .service(service), .current_floor(current_floor), .dir_up(dir_up), .serve(serve),
    .pending_car(pending_car), .pending_up(pending_up), .pending_down(pending_down),
    .target_floor(target_floor), .target_valid(target_valid), .req_here(req_here)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    int cf;
    int up_best, dn_best, first, second;
    int set_floors[$];
    cf = int'(current_floor);
    if (reset) begin
      m_car = '0; m_up = '0; m_dn = '0;
      m_tgt = '0; m_valid = 1'b0; m_here = 1'b0;
      s1_car = btn_num_in; s2_car = btn_num_in;
      s1_up  = btn_up_out; s2_up  = btn_up_out;
      s1_dn  = btn_down_out; s2_dn = btn_down_out;
      return;
    end
    for (int f = 0; f < F; f++) begin
      if (service) begin
        m_car[f] = 1'b0; m_up[f] = 1'b0; m_dn[f] = 1'b0;
      end else begin
        if (s1_car[f] && !s2_car[f]) m_car[f] = 1'b1;
        if (s1_up[f] && !s2_up[f] && f < F - 1) m_up[f] = 1'b1;
        if (s1_dn[f] && !s2_dn[f] && f > 0) m_dn[f] = 1'b1;
        if (serve && cf < F && f == cf) begin
          m_car[f] = 1'b0;
          if (dir_up || f == 0) m_up[f] = 1'b0;
          if (!dir_up || f == F - 1) m_dn[f] = 1'b0;
        end
      end
    end
    s2_car = s1_car; s1_car = btn_num_in;
    s2_up  = s1_up;  s1_up  = btn_up_out;
    s2_dn  = s1_dn;  s1_dn  = btn_down_out;
    if (service || cf >= F) begin
      m_valid = 1'b0; m_here = 1'b0;
    end else begin
      for (int f = 0; f < F; f++)
        if (m_car[f] || m_up[f] || m_dn[f]) set_floors.push_back(f);
      m_here = 1'b0; up_best = -1; dn_best = -1;
      foreach (set_floors[k]) begin
        if (set_floors[k] == cf) m_here = 1'b1;
        if (set_floors[k] > cf && (up_best < 0 || set_floors[k] < up_best)) up_best = set_floors[k];
        if (set_floors[k] < cf && set_floors[k] > dn_best) dn_best = set_floors[k];
      end
      first  = dir_up ? up_best : dn_best;
      second = dir_up ? dn_best : up_best;
      if (first >= 0) begin
        m_valid = 1'b1; m_tgt = FB'(first);
      end else if (second >= 0) begin
        m_valid = 1'b1; m_tgt = FB'(second);
      end else if (m_here) begin
        m_valid = 1'b1; m_tgt = FB'(cf);
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Advance one clock; the model consumes the same pre-edge inputs as the DUT.
  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; serve = 1'b0; service = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    btn_num_in = 6'b000100;
    reset = 1'b1;
    step(2);
    total++;
    if ({pending_car, pending_up, pending_down} !== '0 || target_valid !== 1'b0 ||
        target_floor !== '0 || req_here !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got car=%b up=%b dn=%b tgt=%0d v=%b here=%b want all zero",
               pending_car, pending_up, pending_down, target_floor, target_valid, req_here);
    end
    reset = 1'b0;
    step(3);
    total++;
    if (pending_car !== 6'b000000) begin
      bad++;
      $display("FAIL reset_held_button got=%b want=000000", pending_car);
    end
    btn_num_in = '0;
    step(1);
  endtask

  task automatic test_basic();
    do_reset();
    current_floor = 3'd0; dir_up = 1'b1;
    btn_num_in = 6'b010000;
    step(1);
    total++;
    if (pending_car !== 6'b000000 || target_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_latency got car=%b v=%b want car=000000 v=0", pending_car, target_valid);
    end
    btn_num_in = '0;
    step(1);
    total++;
    if (pending_car !== 6'b010000 || target_floor !== 3'd4 || target_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_press got car=%b tgt=%0d v=%b want car=010000 tgt=4 v=1",
               pending_car, target_floor, target_valid);
    end
    current_floor = 3'd4; serve = 1'b1;
    step(1);
    serve = 1'b0;
    total++;
    if (pending_car !== 6'b000000 || target_valid !== 1'b0 || target_floor !== 3'd4) begin
      bad++;
      $display("FAIL basic_serve got car=%b tgt=%0d v=%b want car=000000 tgt=4 v=0",
               pending_car, target_floor, target_valid);
    end
  endtask

  task automatic test_select();
    do_reset();
    current_floor = 3'd2; dir_up = 1'b1;
    btn_num_in = 6'b100010;
    step(1);
    btn_num_in = '0;
    step(1);
    total++;
    if (target_floor !== 3'd5 || target_valid !== 1'b1) begin
      bad++;
      $display("FAIL select_up got tgt=%0d v=%b want tgt=5 v=1", target_floor, target_valid);
    end
    dir_up = 1'b0;
    step(1);
    total++;
    if (target_floor !== 3'd1 || target_valid !== 1'b1) begin
      bad++;
      $display("FAIL select_down got tgt=%0d v=%b want tgt=1 v=1", target_floor, target_valid);
    end
  endtask

  task automatic test_here();
    do_reset();
    current_floor = 3'd3; dir_up = 1'b1;
    btn_up_out = 6'b001000; btn_down_out = 6'b001000;
    step(1);
    btn_up_out = '0; btn_down_out = '0;
    step(1);
    serve = 1'b1;
    step(1);
    serve = 1'b0;
    total++;
    if (pending_up[3] !== 1'b0 || pending_down[3] !== 1'b1 || req_here !== 1'b1 ||
        target_floor !== 3'd3 || target_valid !== 1'b1) begin
      bad++;
      $display("FAIL here_serve got up3=%b dn3=%b here=%b tgt=%0d v=%b want up3=0 dn3=1 here=1 tgt=3 v=1",
               pending_up[3], pending_down[3], req_here, target_floor, target_valid);
    end
  endtask

  task automatic test_held();
    do_reset();
    current_floor = 3'd2; dir_up = 1'b1;
    btn_num_in = 6'b000100;
    step(2);
    serve = 1'b1;
    step(1);
    serve = 1'b0;
    step(3);
    total++;
    if (pending_car[2] !== 1'b0) begin
      bad++;
      $display("FAIL held_no_reset got=%b want=0", pending_car[2]);
    end
    btn_num_in = '0;
    step(1);
    btn_num_in = 6'b000100;
    step(2);
    total++;
    if (pending_car[2] !== 1'b1) begin
      bad++;
      $display("FAIL held_repress got=%b want=1", pending_car[2]);
    end
    btn_num_in = '0;
  endtask

  task automatic test_ignored();
    do_reset();
    current_floor = 3'd2; dir_up = 1'b1;
    btn_down_out = 6'b000001; btn_up_out = 6'b100000;
    step(2);
    total++;
    if ({pending_car, pending_up, pending_down} !== '0 || target_valid !== 1'b0) begin
      bad++;
      $display("FAIL ignored_ends got up=%b dn=%b v=%b want up=000000 dn=000000 v=0",
               pending_up, pending_down, target_valid);
    end
    btn_down_out = '0; btn_up_out = '0;
    current_floor = 3'd1;
    btn_num_in = 6'b000010;
    step(1);
    serve = 1'b1;
    step(1);
    serve = 1'b0;
    step(1);
    total++;
    if (pending_car[1] !== 1'b0) begin
      bad++;
      $display("FAIL clear_wins got=%b want=0", pending_car[1]);
    end
    btn_num_in = 6'b001000;
    step(1);
    btn_num_in = '0;
    step(1);
    current_floor = 3'd7; serve = 1'b1;
    step(1);
    serve = 1'b0;
    total++;
    if (pending_car !== 6'b001000 || target_valid !== 1'b0 || req_here !== 1'b0) begin
      bad++;
      $display("FAIL out_of_range got car=%b v=%b here=%b want car=001000 v=0 here=0",
               pending_car, target_valid, req_here);
    end
  endtask

  task automatic test_service();
    do_reset();
    current_floor = 3'd2; dir_up = 1'b1;
    btn_num_in = 6'b000001; btn_up_out = 6'b000100; btn_down_out = 6'b100000;
    step(1);
    btn_num_in = '0; btn_up_out = '0; btn_down_out = '0;
    step(1);
    total++;
    if (pending_car !== 6'b000001 || pending_up !== 6'b000100 || pending_down !== 6'b100000) begin
      bad++;
      $display("FAIL service_pre got car=%b up=%b dn=%b want 000001 000100 100000",
               pending_car, pending_up, pending_down);
    end
    service = 1'b1;
    step(1);
    service = 1'b0;
    total++;
    if ({pending_car, pending_up, pending_down} !== '0 || target_valid !== 1'b0 || req_here !== 1'b0) begin
      bad++;
      $display("FAIL service_flush got car=%b up=%b dn=%b v=%b here=%b want all zero",
               pending_car, pending_up, pending_down, target_valid, req_here);
    end
    btn_num_in = 6'b011000; btn_up_out = 6'b000010;
    step(2);
    reset = 1'b1;
    step(1);
    total++;
    if ({pending_car, pending_up, pending_down} !== '0) begin
      bad++;
      $display("FAIL reset_midop got car=%b up=%b want zero", pending_car, pending_up);
    end
    reset = 1'b0;
    step(3);
    total++;
    if ({pending_car, pending_up, pending_down} !== '0) begin
      bad++;
      $display("FAIL reset_release got car=%b up=%b want zero", pending_car, pending_up);
    end
    btn_num_in = '0; btn_up_out = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int f = 0; f < F; f++) begin
        if ($urandom_range(7) == 0) btn_num_in[f]   = ~btn_num_in[f];
        if ($urandom_range(9) == 0) btn_up_out[f]   = ~btn_up_out[f];
        if ($urandom_range(9) == 0) btn_down_out[f] = ~btn_down_out[f];
      end
      current_floor = FB'($urandom_range(7));
      dir_up  = 1'($urandom_range(1));
      serve   = ($urandom_range(3) == 0);
      service = ($urandom_range(39) == 0);
      reset   = ($urandom_range(99) == 0);
      step(1);
      total++;
      if (pending_car !== m_car || pending_up !== m_up || pending_down !== m_dn ||
          target_floor !== m_tgt || target_valid !== m_valid || req_here !== m_here) begin
        bad++;
        $display("FAIL random_c%0d got car=%b up=%b dn=%b tgt=%0d v=%b h=%b want car=%b up=%b dn=%b tgt=%0d v=%b h=%b",
                 c, pending_car, pending_up, pending_down, target_floor, target_valid, req_here,
                 m_car, m_up, m_dn, m_tgt, m_valid, m_here);
      end
    end
    reset = 1'b0; serve = 1'b0; service = 1'b0;
    btn_num_in = '0; btn_up_out = '0; btn_down_out = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_select();
    test_here();
    test_held();
    test_ignored();
    test_service();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
